// File: rtl/data_mem_param.sv
// Parametrised single-port synchronous data memory with byte-enabled writes, an optional
// output register stage and a hardware init sequencer that refills the array after every reset.
module data_mem_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter bit OUT_REG   = 1'b0,
  parameter bit INIT_MODE = 1'b1
) (
  input  logic                  data_mem_clk,
  input  logic                  data_mem_rst,
  input  logic                  data_mem_en,
  input  logic                  data_mem_wr_rd,
  input  logic [ADDR_W-1:0]     data_mem_address,
  input  logic [DATA_W/8-1:0]   data_mem_be,
  input  logic [DATA_W-1:0]     data_mem_data_in,
  output logic [DATA_W-1:0]     data_mem_data_out,
  output logic                  data_mem_rd_valid,
  output logic                  data_mem_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                pipe_valid_q, pipe_valid_d;
  logic [DATA_W-1:0]   pipe_data_q, pipe_data_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [NB-1:0]       mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rd_word;
  logic                rd_fire;

  // Init value for word idx; INIT_MODE=1 keeps the low DATA_W bits of the index.
  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] idx);
    logic [ADDR_W+DATA_W-1:0] wide;
    wide = {{DATA_W{1'b0}}, idx};
    return INIT_MODE ? wide[DATA_W-1:0] : '0;
  endfunction

  assign rd_word = mem_q[data_mem_address];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    mem_we    = '0;
    mem_addr  = data_mem_address;
    mem_wdata = data_mem_data_in;
    rd_fire   = 1'b0;

    case (state_q)
      ST_INIT: begin
        mem_we    = '1;
        mem_addr  = cnt_q;
        mem_wdata = init_word(cnt_q);
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      default: begin
        if (data_mem_en) begin
          if (data_mem_wr_rd) mem_we  = data_mem_be;
          else                rd_fire = 1'b1;
        end
      end
    endcase

    // Read data captured at the request edge, so later writes cannot disturb an in-flight read.
    if (OUT_REG) begin
      pipe_valid_d = rd_fire;
      pipe_data_d  = rd_fire ? rd_word : pipe_data_q;
      rd_valid_d   = pipe_valid_q;
      data_out_d   = pipe_valid_q ? pipe_data_q : data_out_q;
    end else begin
      pipe_valid_d = 1'b0;
      pipe_data_d  = pipe_data_q;
      rd_valid_d   = rd_fire;
      data_out_d   = rd_fire ? rd_word : data_out_q;
    end
  end

  // NOTE: the array has no reset; the init sequencer rewrites every word after each reset.
  always_ff @(posedge data_mem_clk) begin
    for (int k = 0; k < NB; k++) begin
      if (mem_we[k]) mem_q[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge data_mem_clk or posedge data_mem_rst) begin
    if (data_mem_rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      busy_q       <= 1'b1;
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      data_out_q   <= data_out_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign data_mem_data_out = data_out_q;
  assign data_mem_rd_valid = rd_valid_q;
  assign data_mem_busy     = busy_q;

endmodule

// File: tb/tb_data_mem_param.sv
// Directed bench for data_mem_param: default 8x256 (latency 1 and 2) and a 16x16 zero-init variant.
module tb_data_mem_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 8x256 instances (a: OUT_REG=0, c: OUT_REG=1).
  logic       rst_a, rst_c, en, wr;
  logic [7:0] addr, din;
  logic [0:0] be;
  logic [7:0] dout_a, dout_c;
  logic       val_a, val_c, busy_a, busy_c;

  // 16x16, INIT_MODE=0 instance.
  logic        rst_b, en_b, wr_b;
  logic [3:0]  addr_b;
  logic [1:0]  be_b;
  logic [15:0] din_b, dout_b;
  logic        val_b, busy_b;

  data_mem_param u_a (
    .data_mem_clk(clk), .data_mem_rst(rst_a), .data_mem_en(en), .data_mem_wr_rd(wr),
    .data_mem_address(addr), .data_mem_be(be), .data_mem_data_in(din),
    .data_mem_data_out(dout_a), .data_mem_rd_valid(val_a), .data_mem_busy(busy_a)
  );

  data_mem_param #(.OUT_REG(1'b1)) u_c (
    .data_mem_clk(clk), .data_mem_rst(rst_c), .data_mem_en(en), .data_mem_wr_rd(wr),
    .data_mem_address(addr), .data_mem_be(be), .data_mem_data_in(din),
    .data_mem_data_out(dout_c), .data_mem_rd_valid(val_c), .data_mem_busy(busy_c)
  );

  data_mem_param #(.DATA_W(16), .ADDR_W(4), .OUT_REG(1'b0), .INIT_MODE(1'b0)) u_b (
    .data_mem_clk(clk), .data_mem_rst(rst_b), .data_mem_en(en_b), .data_mem_wr_rd(wr_b),
    .data_mem_address(addr_b), .data_mem_be(be_b), .data_mem_data_in(din_b),
    .data_mem_data_out(dout_b), .data_mem_rd_valid(val_b), .data_mem_busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected instance drops busy; n counts edges, early flags any rd_valid seen.
  task automatic wait_init(input int sel, input int bound, output int n, output bit early);
    logic cur_busy, cur_val;
    n = 0;
    early = 1'b0;
    do begin
      step();
      n++;
      case (sel)
        0:       begin cur_busy = busy_a; cur_val = val_a; end
        1:       begin cur_busy = busy_c; cur_val = val_c; end
        default: begin cur_busy = busy_b; cur_val = val_b; end
      endcase
      if (cur_val) early = 1'b1;
    end while (cur_busy && n < bound);
  endtask

  typedef struct {
    logic       en;
    logic       wr;
    logic [7:0] addr;
    logic [0:0] be;
    logic [7:0] din;
    logic       exp_valid;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int   n;
    bit   early;
    logic prev_valid;
    logic [7:0] prev_dout;

    vecs[0]  = '{1'b1, 1'b0, 8'h03, 1'b1, 8'h00, 1'b1, 8'h03};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h03};
    vecs[2]  = '{1'b1, 1'b1, 8'h10, 1'b1, 8'hA5, 1'b0, 8'h03};
    vecs[3]  = '{1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[4]  = '{1'b1, 1'b1, 8'h10, 1'b0, 8'h5A, 1'b0, 8'hA5};
    vecs[5]  = '{1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[6]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 8'hFF};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 1'b1, 8'h77, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h77};
    vecs[10] = '{1'b0, 1'b1, 8'h40, 1'b1, 8'h11, 1'b0, 8'h77};
    vecs[11] = '{1'b1, 1'b0, 8'h40, 1'b0, 8'h00, 1'b1, 8'h40};
    vecs[12] = '{1'b1, 1'b1, 8'h80, 1'b1, 8'h3C, 1'b0, 8'h40};
    vecs[13] = '{1'b1, 1'b0, 8'h80, 1'b0, 8'h00, 1'b1, 8'h3C};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h3C};

    rst_a = 1'b1; rst_c = 1'b1; rst_b = 1'b1;
    en = 1'b0; wr = 1'b0; addr = '0; be = '0; din = '0;
    en_b = 1'b0; wr_b = 1'b0; addr_b = '0; be_b = '0; din_b = '0;

    repeat (3) step();
    check("rst_busy_a", busy_a, 1);
    check("rst_valid_a", val_a, 0);
    check("rst_dout_a", dout_a, 0);
    check("rst_busy_c", busy_c, 1);
    check("rst_dout_b", dout_b, 0);

    // Init of the 8x256 pair while a write to addr 3 and then a read are requested.
    rst_a = 1'b0; rst_c = 1'b0;
    en = 1'b1; wr = 1'b1; addr = 8'h03; din = 8'hFF; be = 1'b1;
    n = 0; early = 1'b0;
    do begin
      step();
      n++;
      if (n == 128) wr = 1'b0;
      if (val_a || val_c) early = 1'b1;
    end while (busy_a && n < 300);
    check("init_len_a", n, 256);
    check("init_done_c", busy_c, 0);
    check("no_valid_during_init", early, 0);

    prev_valid = 1'b0;
    prev_dout  = 8'h00;
    for (int i = 0; i < 15; i++) begin
      en = vecs[i].en; wr = vecs[i].wr; addr = vecs[i].addr; be = vecs[i].be; din = vecs[i].din;
      step();
      check($sformatf("vec%0d_valid_a", i), val_a, vecs[i].exp_valid);
      check($sformatf("vec%0d_dout_a", i), dout_a, vecs[i].exp_dout);
      check($sformatf("vec%0d_valid_c", i), val_c, prev_valid);
      check($sformatf("vec%0d_dout_c", i), dout_c, prev_dout);
      prev_valid = vecs[i].exp_valid;
      prev_dout  = vecs[i].exp_dout;
    end

    // Reset while a latency-2 read is in flight.
    en = 1'b1; wr = 1'b0; addr = 8'h22;
    step();
    rst_c = 1'b1;
    en = 1'b0;
    #1;
    check("midrst_valid_c", val_c, 0);
    check("midrst_busy_c", busy_c, 1);
    check("midrst_dout_c", dout_c, 0);
    step();
    check("midrst_valid_c_next", val_c, 0);
    step();
    rst_c = 1'b0;

    // Reset again once the init counter has reached 100.
    repeat (100) step();
    check("cnt100_busy_c", busy_c, 1);
    rst_c = 1'b1;
    #1;
    check("cnt100_rst_busy_c", busy_c, 1);
    repeat (2) step();
    rst_c = 1'b0;
    en = 1'b1; wr = 1'b0; addr = 8'h80;
    wait_init(1, 300, n, early);
    check("reinit_len_c", n, 256);
    check("reinit_no_valid_c", early, 0);
    step();
    check("reinit_rd_lat1_c", val_c, 0);
    en = 1'b0;
    step();
    check("reinit_rd_valid_c", val_c, 1);
    check("reinit_rd_data_c", dout_c, 8'h80);
    step();
    check("reinit_hold_valid_c", val_c, 0);
    check("reinit_hold_dout_c", dout_c, 8'h80);

    // 16-bit wide, 16-deep, zero-filled instance.
    rst_b = 1'b0;
    wait_init(2, 40, n, early);
    check("init_len_b", n, 16);
    check("init_no_valid_b", early, 0);
    for (int i = 0; i < 16; i++) begin
      en_b = 1'b1; wr_b = 1'b0; addr_b = 4'(i);
      step();
      check($sformatf("zero_valid_b%0d", i), val_b, 1);
      check($sformatf("zero_dout_b%0d", i), dout_b, 16'h0000);
    end
    wr_b = 1'b1; addr_b = 4'd5; din_b = 16'hBEEF; be_b = 2'b11;
    step();
    check("wr_no_valid_b", val_b, 0);
    din_b = 16'h1234; be_b = 2'b01;
    step();
    wr_b = 1'b0;
    step();
    check("be_lo_valid_b", val_b, 1);
    check("be_lo_dout_b", dout_b, 16'hBE34);
    wr_b = 1'b1; din_b = 16'h9900; be_b = 2'b10;
    step();
    wr_b = 1'b0;
    step();
    check("be_hi_dout_b", dout_b, 16'h9934);
    en_b = 1'b0;
    step();
    check("idle_valid_b", val_b, 0);
    check("idle_dout_b", dout_b, 16'h9934);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
